serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Sequencer that time-shares one full-adder cell (the existing `fa` module) to add or subtract two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It holds the operand and result shift registers, the carry flop, a bit counter and a start/busy/done handshake. It targets area-constrained arithmetic in the gate-level library, trading WIDTH cycles of latency for a single adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse when result/cout/overflow are valid
result  output  WIDTH  sum/difference; held until the next accepted start
cout  output  1  final carry-out; for sub, 1 = no borrow
overflow  output  1  two's-complement overflow of the operation

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; shift registers, carry and counter cleared. Reset release is synchronous to clk.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Accept: on a clk edge with start=1 and state in {IDLE, DONE}:
  - A_sr<=a; B_sr<= sub ? ~b : b; carry<=sub; cnt<=0; state<=RUN.
  - result, cout and overflow keep their previous values until the new operation completes.
- Start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- RUN, each edge:
  - fa inputs: a=A_sr[0], b=B_sr[0], cin=carry.
  - A_sr and B_sr shift right by 1.
  - result_sr shifts right with fa.sum entering the MSB.
  - carry<=fa.carry; cnt<=cnt+1.
- Last bit (edge where cnt==WIDTH-1 in RUN):
  - result<=final shifted value; cout<=fa.carry.
  - overflow<=carry^fa.carry, i.e. carry-in of the MSB XOR carry-out of the MSB.
  - state<=DONE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+WIDTH; busy is high for exactly WIDTH cycles.
- DONE exits to IDLE, or to RUN if start=1 on that edge. Back-to-back operations therefore achieve a throughput of one result per WIDTH+1 cycles.
- cnt width is clog2(WIDTH); no wrap occurs because cnt is reloaded on every accept.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-RUN aborts the operation: no done pulse, outputs return to 0.

Decomposition:
- Shared package/include (serial_arith_pkg): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; opcode constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: instantiate the existing `fa` cell, with ports a, b, cin, sum and carry, exactly once. No other adder logic is permitted in this block.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, sub=0, start for 1 cycle -> busy high 8 cycles; done pulses 8 cycles after the start edge; result=0x96, cout=0, overflow=1.
2. a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0 (borrow), overflow=0. Then a=0x7F, b=0x01, sub=0 -> result=0x80, overflow=1. Then a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0.
3. Start a=0x01, b=0x01; pulse start again with a=0xFF, b=0xFF at cycle 3 of RUN -> second request ignored; result=0x02; exactly one done pulse.
4. Assert rst asynchronously (mid-cycle) at bit 4 of a=0xAA+0x55 -> busy, done, result, cout and overflow all 0 immediately. No done after release. A following 0x01+0x02 returns 0x03.
5. Hold start=1 continuously with a=0x03, b=0x04 -> done pulses every 9 cycles; result=0x07 each time; busy low only during the DONE cycles.
6. Exhaustive WIDTH=2 sweep over a, b and sub (32 cases) against a reference model -> result, cout and overflow match for every case.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic sequencers:
// FSM state values and the add/subtract opcode.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage : serial_arith_pkg

// File: rtl/fa.sv
// Single full-adder cell from the gate-level library; the only adder the
// serial sequencer is allowed to use.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (a & cin) | (b & cin);

endmodule : fa

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell processes the
// operands LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_add_ctrl
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_carry;

   fa u_fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .cin   (carry),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; a new request is only taken when not busy
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               accept     = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               next_state = DONE;
               last       = 1'b1;
            end else begin
               next_state = RUN;
            end
         end
         DONE: begin
            if (start) begin
               next_state = RUN;
               accept     = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Handshake flags are registered from the next state so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (next_state == RUN);
         done <= (next_state == DONE);
      end
   end

   // Operand/result shifting, carry and bit counter; subtraction is a + ~b + 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= (sub == OP_SUB) ? ~b : b;
         carry <= (sub == OP_SUB);
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
         carry  <= fa_carry;
         cnt    <= cnt + 1'b1;
         if (last) begin
            result   <= {fa_sum, res_sr[WIDTH-1:1]};
            cout     <= fa_carry;
            overflow <= carry ^ fa_carry;
         end else begin
            result   <= result;
            cout     <= cout;
            overflow <= overflow;
         end
      end else begin
         a_sr <= a_sr;
      end
   end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl: an 8-bit instance for the
// handshake/arithmetic cases and a 2-bit instance swept exhaustively.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, cout, overflow;
   logic [7:0] result;

   logic       start2, sub2;
   logic [1:0] a2, b2;
   logic       busy2, done2, cout2, overflow2;
   logic [1:0] result2;

   int checks;
   int failures;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .result(result2), .cout(cout2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation: checks latency, busy length and the results
   task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                         input logic [7:0] er, input logic ec, input logic eo, input string tag);
      int n;
      int busy_cnt;
      @(negedge clk);
      a = oa; b = ob; sub = os; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!done && n < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, 8);
      check({tag, "_busy_cycles"}, busy_cnt, 8);
      check({tag, "_result"}, result, er);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_overflow"}, overflow, eo);
   endtask

   initial begin
      int n;
      int dones;
      int last_done;
      logic [2:0] sum3;
      logic [1:0] eb;
      logic [1:0] er2;
      logic       eo2;

      checks = 0;
      failures = 0;
      rst = 1'b1;
      start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
      start2 = 1'b0; sub2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
      #3;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_result", result, 8'h00);
      check("reset_cout", cout, 1'b0);
      check("reset_overflow", overflow, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Arithmetic cases
      run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
      run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");

      // Start while busy is ignored
      @(negedge clk);
      a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            check("busy_start_result", result, 8'h02);
         end
         @(negedge clk);
      end
      check("busy_start_done_count", dones, 1);

      // Asynchronous reset in the middle of an operation
      a = 8'hAA; b = 8'h55; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, 8'h00);
      check("abort_cout", cout, 1'b0);
      check("abort_overflow", overflow, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

      // Continuous start: one result every WIDTH+1 cycles
      @(negedge clk);
      a = 8'h03; b = 8'h04; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      dones = 0;
      last_done = -1;
      for (int i = 0; i < 40; i++) begin
         check("stream_busy_not_done", busy ^ done, 1'b1);
         if (done) begin
            check("stream_result", result, 8'h07);
            if (last_done >= 0) check("stream_period", i - last_done, 9);
            last_done = i;
            dones++;
         end
         @(negedge clk);
      end
      check("stream_done_count", dones, 4);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Exhaustive 2-bit sweep
      for (int s = 0; s < 2; s++) begin
         for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
               eb   = (s == 1) ? ~y[1:0] : y[1:0];
               sum3 = {1'b0, x[1:0]} + {1'b0, eb} + {2'b00, s[0]};
               er2  = sum3[1:0];
               eo2  = (x[1] == eb[1]) && (er2[1] != x[1]);
               @(negedge clk);
               a2 = x[1:0]; b2 = y[1:0]; sub2 = s[0]; start2 = 1'b1;
               @(negedge clk);
               start2 = 1'b0;
               n = 0;
               while (!done2 && n < 10) begin
                  @(negedge clk);
                  n++;
               end
               check("w2_latency", n, 2);
               check("w2_result", result2, er2);
               check("w2_cout", cout2, sum3[2]);
               check("w2_overflow", overflow2, eo2);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_add_ctrl
